// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the DIV/IDIV unit.
// master: microcode side driving operands; slave: the divider.
interface divider_if;
   logic        start;
   logic        is_8_bit;
   logic        is_signed;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        complete;
   logic        error;

   modport master (
      output start, is_8_bit, is_signed, dividend, divisor,
      input  quotient, remainder, busy, complete, error
   );

   modport slave (
      input  start, is_8_bit, is_signed, dividend, divisor,
      output quotient, remainder, busy, complete, error
   );
endinterface

// File: rtl/divider.sv
// Iterative restoring DIV/IDIV unit, one quotient bit per clock on operand magnitudes.
// Optional macro DIVIDER_ALLOW_MIN_QUOTIENT_EN accepts a signed quotient of -2^(N-1).
module divider (
   input  logic     clk,
   input  logic     reset,
   divider_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_WORK  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic        is8_q, is8_d;
   logic        sgn_q, sgn_d;
   logic [31:0] dvd_q, dvd_d;
   logic [15:0] dvs_q, dvs_d;
   logic        neg_dvd_q, neg_dvd_d;
   logic        neg_dvs_q, neg_dvs_d;
   logic [15:0] rem_q, rem_d;
   logic [15:0] lo_q, lo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] quot_q, quot_d;
   logic [15:0] remo_q, remo_d;
   logic        err_q, err_d;

   // INIT: operand magnitudes and early error detection
   logic        sd, sv;
   logic [15:0] d16_neg, v16_neg;
   logic [31:0] d32_neg;
   logic [7:0]  v8_neg;
   logic [31:0] dvd_mag;
   logic [15:0] dvs_mag, upper;
   logic        init_err;

   assign d16_neg  = ~dvd_q[15:0] + 16'd1;
   assign d32_neg  = ~dvd_q + 32'd1;
   assign v8_neg   = ~dvs_q[7:0] + 8'd1;
   assign v16_neg  = ~dvs_q + 16'd1;
   assign sd       = sgn_q & (is8_q ? dvd_q[15] : dvd_q[31]);
   assign sv       = sgn_q & (is8_q ? dvs_q[7] : dvs_q[15]);
   assign dvd_mag  = is8_q ? {16'h0000, (sd ? d16_neg : dvd_q[15:0])}
                           : (sd ? d32_neg : dvd_q);
   assign dvs_mag  = is8_q ? {8'h00, (sv ? v8_neg : dvs_q[7:0])}
                           : (sv ? v16_neg : dvs_q);
   assign upper    = is8_q ? {8'h00, dvd_mag[15:8]} : dvd_mag[31:16];
   assign init_err = (dvs_mag == '0) | (upper >= dvs_mag);

   // WORK: shifted remainder never exceeds 17 bits; difference always fits 16
   logic [16:0] shifted;
   logic [15:0] diff;
   logic        fits;
   logic [3:0]  last_cnt;

   assign shifted  = {rem_q, lo_q[15]};
   assign fits     = shifted[16] | (shifted[15:0] >= dvs_q);
   assign diff     = shifted[15:0] - dvs_q;
   assign last_cnt = is8_q ? 4'd7 : 4'd15;

   // FIXUP: sign application and signed range check
   logic [15:0] q_mag, r_mag, q_neg_full, r_neg_full, q_res, r_res, lim;
   logic        neg_q, q_over, fix_err;

   assign q_mag      = is8_q ? {8'h00, lo_q[7:0]} : lo_q;
   assign r_mag      = rem_q;
   assign neg_q      = neg_dvd_q ^ neg_dvs_q;
   assign q_neg_full = neg_q ? (~q_mag + 16'd1) : q_mag;
   assign r_neg_full = neg_dvd_q ? (~r_mag + 16'd1) : r_mag;
   assign q_res      = is8_q ? {8'h00, q_neg_full[7:0]} : q_neg_full;
   assign r_res      = is8_q ? {8'h00, r_neg_full[7:0]} : r_neg_full;
   assign lim        = is8_q ? 16'h007F : 16'h7FFF;

`ifdef DIVIDER_ALLOW_MIN_QUOTIENT_EN
   assign q_over = neg_q ? (q_mag > (lim + 16'd1)) : (q_mag > lim);
`else
   assign q_over = q_mag > lim;
`endif
   assign fix_err = sgn_q & q_over;

   always_comb begin
      state_d   = state_q;
      is8_d     = is8_q;
      sgn_d     = sgn_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      neg_dvd_d = neg_dvd_q;
      neg_dvs_d = neg_dvs_q;
      rem_d     = rem_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      quot_d    = quot_q;
      remo_d    = remo_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               is8_d   = bus.is_8_bit;
               sgn_d   = bus.is_signed;
               dvd_d   = bus.dividend;
               dvs_d   = bus.divisor;
               err_d   = 1'b0;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            neg_dvd_d = sd;
            neg_dvs_d = sv;
            dvs_d     = dvs_mag;
            rem_d     = upper;
            // 8-bit mode left-aligns the low half so WORK always shifts out of bit 15
            lo_d      = is8_q ? {dvd_mag[7:0], 8'h00} : dvd_mag[15:0];
            cnt_d     = '0;
            if (init_err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_WORK;
            end
         end
         S_WORK: begin
            rem_d = fits ? diff : shifted[15:0];
            lo_d  = {lo_q[14:0], fits};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == last_cnt) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (fix_err) begin
               err_d = 1'b1;
            end else begin
               quot_d = q_res;
               remo_d = r_res;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         is8_q     <= 1'b0;
         sgn_q     <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         neg_dvd_q <= 1'b0;
         neg_dvs_q <= 1'b0;
         rem_q     <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         quot_q    <= '0;
         remo_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         is8_q     <= is8_d;
         sgn_q     <= sgn_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         neg_dvd_q <= neg_dvd_d;
         neg_dvs_q <= neg_dvs_d;
         rem_q     <= rem_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         quot_q    <= quot_d;
         remo_q    <= remo_d;
         err_q     <= err_d;
      end
   end

   assign bus.quotient  = quot_q;
   assign bus.remainder = remo_q;
   assign bus.busy      = (state_q == S_INIT) | (state_q == S_WORK) | (state_q == S_FIXUP);
   assign bus.complete  = (state_q == S_DONE);
   assign bus.error     = err_q;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: directed vector table, reset-abort sequence, then randomized ops
// checked against an arithmetic reference model.
module tb_divider;

   logic clk = 1'b0;
   logic reset;

   divider_if bus ();

   divider dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [15:0] prev_q, prev_r;

   typedef struct {
      logic        is8;
      logic        sgn;
      logic [31:0] dvd;
      logic [15:0] dvs;
      int          ex;
      logic [15:0] q;
      logic [15:0] r;
      logic        err;
      int          cyc;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain signed/unsigned integer division with 8086 fault rules.
   function automatic void model(input logic is8, input logic sgn, input logic [31:0] dvd,
                                 input logic [15:0] dvs, input logic [15:0] pq, input logic [15:0] pr,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic err, output int cyc);
      longint a, b, aa, bb, qq, rr, half;
      int n;
      n = is8 ? 8 : 16;
      half = longint'(1) << (n - 1);
      if (is8) begin
         a = sgn ? longint'($signed(dvd[15:0])) : longint'(dvd[15:0]);
         b = sgn ? longint'($signed(dvs[7:0]))  : longint'(dvs[7:0]);
      end else begin
         a = sgn ? longint'($signed(dvd)) : longint'(dvd);
         b = sgn ? longint'($signed(dvs)) : longint'(dvs);
      end
      aa = (a < 0) ? -a : a;
      bb = (b < 0) ? -b : b;
      q = pq;
      r = pr;
      err = 1'b1;
      cyc = 2;
      if (bb != 0 && (aa / bb) < (longint'(1) << n)) begin
         qq = a / b;
         rr = a % b;
         cyc = n + 3;
`ifdef DIVIDER_ALLOW_MIN_QUOTIENT_EN
         if (sgn && (qq > half - 1 || qq < -half)) err = 1'b1;
`else
         if (sgn && (qq > half - 1 || qq <= -half)) err = 1'b1;
`endif
         else begin
            err = 1'b0;
            q = is8 ? {8'h00, qq[7:0]} : qq[15:0];
            r = is8 ? {8'h00, rr[7:0]} : rr[15:0];
         end
      end
   endfunction

   task automatic run_op(input logic is8, input logic sgn, input logic [31:0] dvd, input logic [15:0] dvs,
                         input int ex_cyc, input logic [15:0] eq, input logic [15:0] er,
                         input logic ee, input int ecyc, input string tag);
      int cyc;
      bit got;
      bit busy_bad;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_8_bit  = is8;
      bus.is_signed = sgn;
      bus.dividend  = dvd;
      bus.divisor   = dvs;
      cyc = 0;
      got = 1'b0;
      busy_bad = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.complete === 1'b1) got = 1'b1;
         else if (bus.busy !== 1'b1) busy_bad = 1'b1;
         bus.start = (cyc == ex_cyc);
         if (cyc == ex_cyc) begin
            bus.is_8_bit  = 1'($urandom);
            bus.is_signed = 1'($urandom);
            bus.dividend  = $urandom;
            bus.divisor   = 16'($urandom);
         end
      end
      chk({tag, " complete_cycle"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(ecyc));
      chk({tag, " busy_before_complete"}, {31'd0, busy_bad}, 32'd0);
      chk({tag, " busy_at_complete"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, " quotient"}, {16'd0, bus.quotient}, {16'd0, eq});
      chk({tag, " remainder"}, {16'd0, bus.remainder}, {16'd0, er});
      chk({tag, " error"}, {31'd0, bus.error}, {31'd0, ee});
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " idle_after_done"}, {30'd0, bus.busy, bus.complete}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] mq, mr;
      logic        me;
      int          mc;
      bit          saw;
      logic signed [31:0] s32;
      logic signed [15:0] s16;
      logic        ris8, rsgn;
      logic [31:0] rdvd;
      logic [15:0] rdvs;

      tbl[0]  = '{1'b0, 1'b0, 32'h0001_0000, 16'h0003, 0,  16'h5555, 16'h0001, 1'b0, 19};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0064, 16'h0007, 5,  16'h000E, 16'h0002, 1'b0, 11};
      tbl[2]  = '{1'b0, 1'b0, 32'h0000_1234, 16'h0001, 0,  16'h1234, 16'h0000, 1'b0, 19};
      tbl[3]  = '{1'b0, 1'b0, 32'h0000_0005, 16'h0000, 0,  16'h1234, 16'h0000, 1'b1, 2};
      tbl[4]  = '{1'b1, 1'b0, 32'h0000_0064, 16'h0007, 11, 16'h000E, 16'h0002, 1'b0, 11};
      tbl[5]  = '{1'b0, 1'b0, 32'h0002_0000, 16'h0002, 0,  16'h000E, 16'h0002, 1'b1, 2};
      tbl[6]  = '{1'b1, 1'b1, 32'h0000_FF9C, 16'h00F9, 0,  16'h000E, 16'h00FE, 1'b0, 11};
      tbl[7]  = '{1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 0,  16'h00F2, 16'h00FE, 1'b0, 11};
`ifdef DIVIDER_ALLOW_MIN_QUOTIENT_EN
      tbl[8]  = '{1'b1, 1'b1, 32'h0000_FF80, 16'h0001, 0,  16'h0080, 16'h0000, 1'b0, 11};
      tbl[9]  = '{1'b1, 1'b1, 32'h0000_0080, 16'h0001, 0,  16'h0080, 16'h0000, 1'b1, 11};
`else
      tbl[8]  = '{1'b1, 1'b1, 32'h0000_FF80, 16'h0001, 0,  16'h00F2, 16'h00FE, 1'b1, 11};
      tbl[9]  = '{1'b1, 1'b1, 32'h0000_0080, 16'h0001, 0,  16'h00F2, 16'h00FE, 1'b1, 11};
`endif
      tbl[10] = '{1'b0, 1'b1, 32'h0000_0007, 16'hFFFE, 0,  16'hFFFD, 16'h0001, 1'b0, 19};
      tbl[11] = '{1'b1, 1'b0, 32'hABCD_0064, 16'hFF07, 0,  16'h000E, 16'h0002, 1'b0, 11};
      tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002, 0,  16'hFFFD, 16'hFFFF, 1'b0, 19};

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.is_8_bit  = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {bus.quotient, bus.remainder}, 32'd0);
      chk("reset_flags", {29'd0, bus.busy, bus.complete, bus.error}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_flags", {29'd0, bus.busy, bus.complete, bus.error}, 32'd0);

      for (int i = 0; i < 13; i++)
         run_op(tbl[i].is8, tbl[i].sgn, tbl[i].dvd, tbl[i].dvs, tbl[i].ex,
                tbl[i].q, tbl[i].r, tbl[i].err, tbl[i].cyc, $sformatf("vec%0d", i));

      // Reset in cycle 7 of a 16-bit op aborts with no completion.
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_8_bit  = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'h0001_0000;
      bus.divisor   = 16'h0003;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("midop_busy", {31'd0, bus.busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_results", {bus.quotient, bus.remainder}, 32'd0);
      chk("abort_flags", {29'd0, bus.busy, bus.complete, bus.error}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      saw = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (bus.complete !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
      end
      chk("abort_no_complete", {31'd0, saw}, 32'd0);
      prev_q = '0;
      prev_r = '0;

      for (int i = 0; i < 300; i++) begin
         ris8 = 1'($urandom);
         rsgn = 1'($urandom);
         s32  = $urandom;
         s32  = s32 >>> $urandom_range(0, 24);
         s16  = 16'($urandom);
         s16  = s16 >>> $urandom_range(0, 12);
         rdvd = ris8 ? {16'($urandom), s16} : s32;
         if ($urandom_range(0, 9) == 0) rdvs = '0;
         else if ($urandom_range(0, 3) == 0) rdvs = 16'($urandom_range(1, 3));
         else rdvs = 16'($urandom);
         model(ris8, rsgn, rdvd, rdvs, prev_q, prev_r, mq, mr, me, mc);
         run_op(ris8, rsgn, rdvd, rdvs, $urandom_range(0, 20), mq, mr, me, mc,
                $sformatf("rnd%0d", i));
         prev_q = mq;
         prev_r = mr;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative multi-cycle divide unit for DIV/IDIV, one quotient bit per clock, restoring algorithm on operand magnitudes.
- Operands come from the microcode register-read stage.
- Quotient/remainder are routed back through the ALU SELA/SELB path for writeback, so this block feeds the ALU.
- The divide-error flag drives the microcode INT 0 fault sequence.

Parameters:
- none (width fixed at 8086 word size; 8-bit mode selected per operation)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin division; sampled only in IDLE
- is_8_bit  input  1  1: AX / r8, 0: DX:AX / r16
- is_signed  input  1  1: IDIV, 0: DIV
- dividend  input  32  8-bit mode uses [15:0] only
- divisor  input  16  8-bit mode uses [7:0] only
- quotient  output  16  registered; 8-bit mode result in [7:0], [15:8]=0
- remainder  output  16  registered; 8-bit mode result in [7:0], [15:8]=0
- busy  output  1  high while operation in flight
- complete  output  1  single-cycle pulse, results/error valid
- error  output  1  divide error; valid with complete, held until next start

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE; quotient, remainder, busy, complete and error all 0. Reset mid-operation aborts immediately with no complete pulse.
- Let N = 8 (8-bit mode) or 16 (16-bit mode). Inputs are captured on the edge where start=1 in IDLE, called edge 0. Inputs are don't-care afterwards.
- States:
  - IDLE -> INIT on start.
  - INIT: take magnitudes (two's-complement abs when is_signed; sign of dividend and of divisor latched).
    - Divisor magnitude 0 -> error path.
    - Upper-half magnitude (bits [2N-1:N]) >= divisor magnitude -> error path.
    - Otherwise -> WORK.
  - WORK: N cycles. Shift partial remainder and quotient left one bit; subtract divisor; restore if negative. A counter runs 0..N-1.
  - FIXUP:
    - Quotient negated if dividend sign != divisor sign; remainder negated if dividend negative.
    - Signed range check: positive quotient magnitude > 2^(N-1)-1 -> error; negative quotient magnitude > 2^(N-1)-1 -> error (8086 behaviour, -2^(N-1) rejected).
    - -> DONE.
  - DONE: complete=1 for one cycle; -> IDLE.
- Timing, with cycle k being the cycle after edge k-1:
  - busy=1 in cycles 1..N+2.
  - complete=1 in cycle N+3 (cycle 11 for 8-bit, cycle 19 for 16-bit).
  - Error path from INIT: skip to DONE; complete=1 in cycle 2.
- Error: error=1 with complete; quotient and remainder retain their previous values. error clears on the next accepted start.
- Success: quotient and remainder update at the edge entering DONE and hold until the next successful completion.
- start while not IDLE (including during DONE) is ignored; there is no queueing.
- Remainder sign always follows the dividend sign (truncating division).
- Unsigned mode: INIT check alone guarantees the quotient fits; FIXUP never errors.
- 8-bit mode: bits above [2N-1] of dividend and [N-1] of divisor are ignored; sign is taken from dividend[15] and divisor[7].

Optional Feature:
- Macro: DIVIDER_ALLOW_MIN_QUOTIENT_EN.
- Defined: signed quotient exactly -2^(N-1) (0x80 / 0x8000) is accepted as a valid result with error=0 (80186+ behaviour).
- Undefined: that case raises error as described above.
- All other behaviour and timing are identical either way.

Test Plan:
- 16-bit unsigned: dividend 0x00010000, divisor 0x0003 -> quotient 0x5555, remainder 0x0001, error 0, complete in cycle 19, busy high cycles 1-18.
- 8-bit unsigned: dividend 0x0064, divisor 0x07 -> quotient 0x000E, remainder 0x0002, complete in cycle 11. A second start pulse in cycle 5 is ignored.
- Divide by zero: prior quotient 0x1234, divisor 0x0000 -> error 1, complete in cycle 2, quotient still 0x1234. Next valid start clears error.
- Unsigned overflow: dividend 0x00020000, divisor 0x0002 -> error 1 in cycle 2. Reset asserted in cycle 7 of a 16-bit op -> all outputs 0 immediately, no complete.
- 8-bit signed: dividend 0xFF9C (-100), divisor 0xF9 (-7) -> quotient 0x000E, remainder 0x00FE (-2). Divisor 0x07 -> quotient 0x00F2, remainder 0x00FE.
- Signed min quotient: dividend 0xFF80, divisor 0x01, 8-bit signed -> error 1 without macro; quotient 0x0080, remainder 0x0000, error 0 with DIVIDER_ALLOW_MIN_QUOTIENT_EN. Dividend 0x0080, divisor 0x01 -> error 1 in both builds.
